// File: rtl/alu_pkg.sv
// Shared ALU definitions: option codes, muldiv FSM state encoding, default width.
// Optional divide path of muldiv is controlled by macro MULDIV_DIV_EN.
package alu_pkg;

  localparam int unsigned MULDIV_WIDTH = 32;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0010;
  localparam logic [3:0] OP_OR  = 4'b0011;
  localparam logic [3:0] OP_XOR = 4'b0100;
  localparam logic [3:0] OP_SLL = 4'b0101;
  localparam logic [3:0] OP_SRL = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_MUL = 4'b1000;
  localparam logic [3:0] OP_DIV = 4'b1001;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_CALC = 2'd1,
    MD_DONE = 2'd2
  } muldiv_state_e;

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration of the multi-cycle muldiv: shift-add multiply
// or restoring divide on a {hi,lo} accumulator. Divide only with MULDIV_DIV_EN.
module muldiv_step
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = MULDIV_WIDTH
) (
  input  logic [3:0]         op,
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   operand,
  output logic [2*WIDTH-1:0] acc_next
);

  // Multiply: acc = {partial product, remaining multiplier bits}.
  logic [WIDTH:0] add_sum;
  assign add_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, operand};

`ifdef MULDIV_DIV_EN
  // Divide: acc = {remainder, dividend bits / quotient bits}.
  logic [WIDTH:0] rem_shift;
  logic [WIDTH:0] rem_diff;
  assign rem_shift = acc[2*WIDTH-1:WIDTH-1];
  assign rem_diff  = rem_shift - {1'b0, operand};
`endif

  // Select one iteration of the active operation.
  always_comb begin
    acc_next = acc;
    if (op == OP_MUL) begin
      if (acc[0]) acc_next = {add_sum, acc[WIDTH-1:1]};
      else        acc_next = {1'b0, acc[2*WIDTH-1:1]};
    end
`ifdef MULDIV_DIV_EN
    else if (op == OP_DIV) begin
      // Bit WIDTH of the difference is the borrow: set means restore.
      if (!rem_diff[WIDTH]) acc_next = {rem_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      else                  acc_next = {rem_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end
`endif
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle unsigned multiply/divide sequencer: IDLE -> CALC (WIDTH cycles)
// -> DONE. Divide path present only when macro MULDIV_DIV_EN is defined.
module muldiv_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = MULDIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       option,
  input  logic [WIDTH-1:0] oprd1,
  input  logic [WIDTH-1:0] oprd2,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  muldiv_state_e      state;
  logic [CW-1:0]      cnt;
  logic [3:0]         op_q;
  logic [WIDTH-1:0]   operand_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] acc_next;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .op       (op_q),
    .acc      (acc_q),
    .operand  (operand_q),
    .acc_next (acc_next)
  );

  // FSM, iteration counter, operand latches and registered result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= MD_IDLE;
      cnt       <= '0;
      op_q      <= '0;
      operand_q <= '0;
      acc_q     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      zero      <= 1'b0;
      hi        <= '0;
      lo        <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        MD_IDLE: begin
          if (start && option == OP_MUL) begin
            op_q      <= option;
            operand_q <= oprd1;
            acc_q     <= {{WIDTH{1'b0}}, oprd2};
            cnt       <= '0;
            busy      <= 1'b1;
            state     <= MD_CALC;
          end else if (start && option == OP_DIV) begin
`ifdef MULDIV_DIV_EN
            if (oprd2 == '0) begin
              busy  <= 1'b1;
              done  <= 1'b1;
              err   <= 1'b1;
              zero  <= 1'b0;
              hi    <= oprd1;
              lo    <= '1;
              state <= MD_DONE;
            end else begin
              op_q      <= option;
              operand_q <= oprd2;
              acc_q     <= {{WIDTH{1'b0}}, oprd1};
              cnt       <= '0;
              busy      <= 1'b1;
              state     <= MD_CALC;
            end
`else
            busy  <= 1'b1;
            done  <= 1'b1;
            err   <= 1'b1;
            zero  <= 1'b1;
            hi    <= '0;
            lo    <= '0;
            state <= MD_DONE;
`endif
          end
        end
        MD_CALC: begin
          acc_q <= acc_next;
          cnt   <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) begin
            done  <= 1'b1;
            err   <= 1'b0;
            hi    <= acc_next[2*WIDTH-1:WIDTH];
            lo    <= acc_next[WIDTH-1:0];
            zero  <= (acc_next[WIDTH-1:0] == '0);
            state <= MD_DONE;
          end
        end
        MD_DONE: begin
          busy  <= 1'b0;
          state <= MD_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= MD_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer (WIDTH=32); divide expectations
// follow macro MULDIV_DIV_EN.
module tb_muldiv_sequencer;
  import alu_pkg::*;

  localparam int unsigned W = 32;
  localparam int LAT_CALC = W + 1;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [3:0]   option;
  logic [W-1:0] oprd1, oprd2;
  logic         busy, done, err, zero;
  logic [W-1:0] hi, lo;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  muldiv_sequencer #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .option (option),
    .oprd1  (oprd1),
    .oprd2  (oprd2),
    .busy   (busy),
    .done   (done),
    .err    (err),
    .zero   (zero),
    .hi     (hi),
    .lo     (lo)
  );

  typedef struct {
    string        name;
    logic [3:0]   op;
    logic [W-1:0] a, b;
    logic [W-1:0] e_hi, e_lo;
    logic         e_err, e_zero;
    int           e_lat;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input string name, input logic [3:0] op, input logic [W-1:0] a,
                              input logic [W-1:0] b, input logic [W-1:0] e_hi,
                              input logic [W-1:0] e_lo, input logic e_err,
                              input logic e_zero, input int e_lat);
    vec_t v;
    v.name = name; v.op = op; v.a = a; v.b = b;
    v.e_hi = e_hi; v.e_lo = e_lo; v.e_err = e_err; v.e_zero = e_zero; v.e_lat = e_lat;
    return v;
  endfunction

  // Reference model from plain arithmetic.
  function automatic vec_t model(input string name, input logic [3:0] op,
                                 input logic [W-1:0] a, input logic [W-1:0] b);
    vec_t v;
    logic [63:0] p;
    v.name = name; v.op = op; v.a = a; v.b = b;
    if (op == OP_MUL) begin
      p = {32'b0, a} * {32'b0, b};
      v.e_hi = p[63:32]; v.e_lo = p[31:0]; v.e_err = 1'b0; v.e_lat = LAT_CALC;
    end else begin
`ifdef MULDIV_DIV_EN
      if (b == 0) begin
        v.e_hi = a; v.e_lo = 32'hFFFF_FFFF; v.e_err = 1'b1; v.e_lat = 1;
      end else begin
        v.e_hi = a % b; v.e_lo = a / b; v.e_err = 1'b0; v.e_lat = LAT_CALC;
      end
`else
      v.e_hi = 0; v.e_lo = 0; v.e_err = 1'b1; v.e_lat = 1;
`endif
    end
    v.e_zero = (v.e_lo == 0);
    return v;
  endfunction

  // Start one op and wait (bounded) for done; optionally inject a stray start.
  task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int inject, output logic [W-1:0] r_hi, output logic [W-1:0] r_lo,
                        output logic r_err, output logic r_zero, output int lat,
                        output logic stable);
    logic [W-1:0] hi0, lo0;
    hi0 = hi; lo0 = lo; stable = 1'b1;
    start = 1'b1; option = op; oprd1 = a; oprd2 = b;
    @(posedge clk); #1;
    start = 1'b0; oprd1 = $urandom; oprd2 = $urandom;
    lat = 1;
    while (!done && lat < 100) begin
      if (hi !== hi0 || lo !== lo0 || busy !== 1'b1) stable = 1'b0;
      if (lat == inject) begin
        start = 1'b1; option = OP_MUL; oprd1 = 9; oprd2 = 9;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    r_hi = hi; r_lo = lo; r_err = err; r_zero = zero;
  endtask

  task automatic run_and_check(input vec_t v, input int inject);
    logic [W-1:0] rh, rl;
    logic re, rz, st;
    int lat;
    run_op(v.op, v.a, v.b, inject, rh, rl, re, rz, lat, st);
    check($sformatf("%s latency", v.name), lat, v.e_lat);
    check($sformatf("%s hi", v.name), rh, v.e_hi);
    check($sformatf("%s lo", v.name), rl, v.e_lo);
    check($sformatf("%s err", v.name), re, v.e_err);
    check($sformatf("%s zero", v.name), rz, v.e_zero);
    check($sformatf("%s hold_while_busy", v.name), st, 1'b1);
    @(posedge clk); #1;
    check($sformatf("%s done_pulse_end", v.name), done, 1'b0);
    check($sformatf("%s idle_after_done", v.name), busy, 1'b0);
    check($sformatf("%s lo_held", v.name), lo, v.e_lo);
  endtask

  initial begin
    logic [W-1:0] hi0, lo0, ra, rb;
    logic [3:0]   bad_ops [2];
    logic         seen;
    vec_t         v;

    rst = 1'b1; start = 1'b0; option = '0; oprd1 = '0; oprd2 = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset err", err, 0);
    check("reset zero", zero, 0);
    check("reset hi", hi, 0);
    check("reset lo", lo, 0);
    rst = 1'b0;

    vecs.push_back(mk("mul 7x6", OP_MUL, 7, 6, 0, 42, 0, 0, LAT_CALC));
    vecs.push_back(mk("mul max", OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                      32'hFFFF_FFFE, 32'h0000_0001, 0, 0, LAT_CALC));
    vecs.push_back(mk("mul 0x", OP_MUL, 0, 32'h1234_5678, 0, 0, 0, 1, LAT_CALC));
    vecs.push_back(mk("mul hi", OP_MUL, 32'h8000_0000, 4, 2, 0, 0, 1, LAT_CALC));
`ifdef MULDIV_DIV_EN
    vecs.push_back(mk("div 100/7", OP_DIV, 100, 7, 2, 14, 0, 0, LAT_CALC));
    vecs.push_back(mk("div 5/9", OP_DIV, 5, 9, 5, 0, 0, 1, LAT_CALC));
    vecs.push_back(mk("div 5/0", OP_DIV, 5, 0, 5, 32'hFFFF_FFFF, 1, 0, 1));
    vecs.push_back(mk("div max/1", OP_DIV, 32'hFFFF_FFFF, 1, 0, 32'hFFFF_FFFF, 0, 0, LAT_CALC));
    vecs.push_back(mk("div max/max", OP_DIV, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1, 0, 0, LAT_CALC));
`else
    vecs.push_back(mk("div 100/7", OP_DIV, 100, 7, 0, 0, 1, 1, 1));
    vecs.push_back(mk("div 5/9", OP_DIV, 5, 9, 0, 0, 1, 1, 1));
    vecs.push_back(mk("div 5/0", OP_DIV, 5, 0, 0, 0, 1, 1, 1));
`endif
    vecs.push_back(mk("mul after div", OP_MUL, 32'h0001_0000, 32'h0001_0000, 1, 0, 0, 1, LAT_CALC));

    foreach (vecs[i]) run_and_check(vecs[i], -1);

    // Illegal options in IDLE are ignored.
    bad_ops[0] = 4'b0010;
    bad_ops[1] = 4'b1111;
    for (int i = 0; i < 2; i++) begin
      hi0 = hi; lo0 = lo;
      start = 1'b1; option = bad_ops[i]; oprd1 = $urandom; oprd2 = $urandom;
      for (int c = 0; c < 3; c++) begin
        @(posedge clk); #1;
        check($sformatf("illegal op %b busy", bad_ops[i]), busy, 0);
        check($sformatf("illegal op %b done", bad_ops[i]), done, 0);
      end
      start = 1'b0;
      check($sformatf("illegal op %b hi", bad_ops[i]), hi, hi0);
      check($sformatf("illegal op %b lo", bad_ops[i]), lo, lo0);
    end

    // Stray multiply start at T+5 of a running op must not disturb it.
    run_and_check(mk("mul 7x6 with stray start", OP_MUL, 7, 6, 0, 42, 0, 0, LAT_CALC), 5);

    // Reset at T+10 of a multiply aborts it with no done.
    start = 1'b1; option = OP_MUL; oprd1 = 123; oprd2 = 456;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort busy", busy, 0);
    check("abort done", done, 0);
    check("abort err", err, 0);
    check("abort zero", zero, 0);
    check("abort hi", hi, 0);
    check("abort lo", lo, 0);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done || busy) seen = 1'b1;
    end
    check("abort no done", seen, 0);
    run_and_check(mk("mul 3x3 after abort", OP_MUL, 3, 3, 0, 9, 0, 0, LAT_CALC), -1);

    // Randomized ops against the arithmetic model.
    for (int i = 0; i < 30; i++) begin
      ra = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 1000)) : W'($urandom);
      case ($urandom_range(0, 9))
        0:       rb = '0;
        1, 2, 3: rb = W'($urandom_range(1, 255));
        default: rb = W'($urandom);
      endcase
      v = model($sformatf("rnd%0d", i), ($urandom_range(0, 1) == 1) ? OP_MUL : OP_DIV, ra, rb);
      run_and_check(v, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
